// File: rtl/sccb_pkg.sv
// Shared types and constants for the SCCB target register file.
package sccb_pkg;

   typedef enum logic [3:0] {
      IDLE,
      ADDR,
      ADDR_ACK,
      SUB,
      SUB_ACK,
      WDATA,
      WDATA_ACK,
      RDATA,
      RDATA_ACK,
      IGNORE
   } sccbState_t;

   localparam logic       SCCB_RD_BIT     = 1'b1;
   localparam logic       SCCB_WR_BIT     = 1'b0;
   localparam logic [6:0] SCCB_DEFAULT_ID = 7'h21;

endpackage

// File: rtl/sccb_line_sync.sv
// SCL/SDA synchroniser with edge, START and STOP pulse detection.
module sccb_line_sync #(
   parameter int STAGES = 2
) (
   input  logic iCLK,
   input  logic iRST,
   input  logic iScl,
   input  logic iSda,
   output logic oSda,
   output logic oSclRise,
   output logic oSclFall,
   output logic oStart,
   output logic oStop
);

   logic [STAGES-1:0] sclPipe;
   logic [STAGES-1:0] sdaPipe;
   logic              sclQ;
   logic              sdaQ;
   logic              scl;
   logic              sda;

   // Reset to the idle-bus level so no false edge appears after reset.
   always_ff @(posedge iCLK) begin
      if (iRST) begin
         sclPipe <= '1;
         sdaPipe <= '1;
         sclQ    <= 1'b1;
         sdaQ    <= 1'b1;
      end else begin
         sclPipe <= {sclPipe[STAGES-2:0], iScl};
         sdaPipe <= {sdaPipe[STAGES-2:0], iSda};
         sclQ    <= scl;
         sdaQ    <= sda;
      end
   end

   assign scl      = sclPipe[STAGES-1];
   assign sda      = sdaPipe[STAGES-1];
   assign oSda     = sda;
   assign oSclRise = scl & ~sclQ;
   assign oSclFall = ~scl & sclQ;
   assign oStart   = scl & sclQ & sdaQ & ~sda;
   assign oStop    = scl & sclQ & ~sdaQ & sda;

endmodule

// File: rtl/sccb_slave_regfile.sv
// SCCB/I2C target with a 256x8 register file and auto-incrementing
// sub-address; SDA is only ever pulled low.
module sccb_slave_regfile
   import sccb_pkg::*;
#(
   parameter logic [6:0] SLAVE_ADDR  = SCCB_DEFAULT_ID,
   parameter int         SYNC_STAGES = 2
) (
   input  logic        iCLK,
   input  logic        iRST,
   input  logic        I2C_SCLK,
   inout  wire         I2C_SDAT,
   output logic        oSDA_OE,
   input  logic [7:0]  iRD_ADDR,
   output logic [7:0]  oRD_DATA,
   output logic        oWR_STROBE,
   output logic [7:0]  oWR_ADDR,
   output logic [7:0]  oWR_DATA,
   output logic        oBUSY,
   output logic [15:0] oWR_COUNT
);

   sccbState_t state, stateN;
   logic [7:0] regs [256];
   logic [7:0] shiftReg, shiftN;
   logic [3:0] bitCnt, bitN;
   logic [7:0] ptr, ptrN;
   logic [7:0] rdIdx;
   logic [7:0] rdByte;
   logic       sdaOe, oeN;
   logic       busy, busyN;
   logic       rw, rwN;
   logic       wrEn;
   logic       sda, sclRise, sclFall, start, stop;

   sccb_line_sync #(
      .STAGES (SYNC_STAGES)
   ) uSync (
      .iCLK     (iCLK),
      .iRST     (iRST),
      .iScl     (I2C_SCLK),
      .iSda     (I2C_SDAT),
      .oSda     (sda),
      .oSclRise (sclRise),
      .oSclFall (sclFall),
      .oStart   (start),
      .oStop    (stop)
   );

   assign I2C_SDAT = sdaOe ? 1'b0 : 1'bz;
   assign oSDA_OE  = sdaOe;
   assign oBUSY    = busy;

   // After a master ACK the next byte comes from ptr+1.
   assign rdIdx  = (state == RDATA_ACK) ? ptr + 8'd1 : ptr;
   assign rdByte = regs[rdIdx];

   always_comb begin
      stateN = state;
      shiftN = shiftReg;
      bitN   = bitCnt;
      ptrN   = ptr;
      oeN    = sdaOe;
      busyN  = busy;
      rwN    = rw;
      wrEn   = 1'b0;
      if (start) begin
         stateN = ADDR;
         bitN   = 4'd0;
         oeN    = 1'b0;
      end else if (stop) begin
         stateN = IDLE;
         bitN   = 4'd0;
         oeN    = 1'b0;
         busyN  = 1'b0;
      end else begin
         unique case (state)
            ADDR: begin
               if (bitCnt == 4'd8) begin
                  bitN = 4'd0;
                  if (shiftReg[7:1] == SLAVE_ADDR) begin
                     busyN  = 1'b1;
                     rwN    = shiftReg[0];
                     stateN = ADDR_ACK;
                  end else begin
                     busyN  = 1'b0;
                     stateN = IGNORE;
                  end
               end else if (sclRise) begin
                  shiftN = {shiftReg[6:0], sda};
                  bitN   = bitCnt + 4'd1;
               end
            end
            SUB: begin
               if (bitCnt == 4'd8) begin
                  bitN   = 4'd0;
                  ptrN   = shiftReg;
                  stateN = SUB_ACK;
               end else if (sclRise) begin
                  shiftN = {shiftReg[6:0], sda};
                  bitN   = bitCnt + 4'd1;
               end
            end
            WDATA: begin
               if (bitCnt == 4'd8) begin
                  bitN   = 4'd0;
                  wrEn   = 1'b1;
                  ptrN   = ptr + 8'd1;
                  stateN = WDATA_ACK;
               end else if (sclRise) begin
                  shiftN = {shiftReg[6:0], sda};
                  bitN   = bitCnt + 4'd1;
               end
            end
            ADDR_ACK, SUB_ACK, WDATA_ACK: begin
               if (sclFall) begin
                  if (!sdaOe) begin
                     oeN = 1'b1;
                  end else begin
                     oeN  = 1'b0;
                     bitN = 4'd0;
                     if (state == ADDR_ACK && rw == SCCB_RD_BIT) begin
                        // Release edge is also where read bit 7 goes out.
                        oeN    = ~rdByte[7];
                        shiftN = {rdByte[6:0], 1'b0};
                        bitN   = 4'd1;
                        stateN = RDATA;
                     end else if (state == ADDR_ACK) begin
                        stateN = SUB;
                     end else begin
                        stateN = WDATA;
                     end
                  end
               end
            end
            RDATA: begin
               if (sclFall) begin
                  if (bitCnt == 4'd8) begin
                     oeN    = 1'b0;
                     bitN   = 4'd0;
                     stateN = RDATA_ACK;
                  end else begin
                     oeN    = ~shiftReg[7];
                     shiftN = {shiftReg[6:0], 1'b0};
                     bitN   = bitCnt + 4'd1;
                  end
               end
            end
            RDATA_ACK: begin
               if (sclRise) begin
                  if (!sda) begin
                     ptrN   = ptr + 8'd1;
                     shiftN = rdByte;
                     bitN   = 4'd0;
                     stateN = RDATA;
                  end else begin
                     stateN = IGNORE;
                  end
               end
            end
            default: begin
            end
         endcase
      end
   end

   always_ff @(posedge iCLK) begin
      if (iRST) begin
         state      <= IDLE;
         shiftReg   <= '0;
         bitCnt     <= '0;
         ptr        <= '0;
         sdaOe      <= 1'b0;
         busy       <= 1'b0;
         rw         <= SCCB_WR_BIT;
         oRD_DATA   <= '0;
         oWR_STROBE <= 1'b0;
         oWR_ADDR   <= '0;
         oWR_DATA   <= '0;
         oWR_COUNT  <= '0;
         for (int i = 0; i < 256; i++) begin
            regs[i] <= '0;
         end
      end else begin
         state      <= stateN;
         shiftReg   <= shiftN;
         bitCnt     <= bitN;
         ptr        <= ptrN;
         sdaOe      <= oeN;
         busy       <= busyN;
         rw         <= rwN;
         oRD_DATA   <= regs[iRD_ADDR];
         oWR_STROBE <= wrEn;
         if (wrEn) begin
            regs[ptr] <= shiftReg;
            oWR_ADDR  <= ptr;
            oWR_DATA  <= shiftReg;
            if (oWR_COUNT != 16'hFFFF) begin
               oWR_COUNT <= oWR_COUNT + 16'd1;
            end
         end
      end
   end

endmodule

// File: tb/tb_sccb_slave_regfile.sv
// Directed bench: bit-banged SCCB master, transaction-level register model.
module tb_sccb_slave_regfile;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        scl = 1'b1;
   logic        mLow = 1'b0;
   logic [7:0]  rdAddr = 8'h00;
   wire         sdaBus;
   logic        oe;
   logic [7:0]  rdData;
   logic        wrStrobe;
   logic [7:0]  wrAddr;
   logic [7:0]  wrData;
   logic        busy;
   logic [15:0] wrCount;

   int compared = 0;
   int mismatched = 0;

   logic [7:0]  mReg [256];
   int          mCount = 0;
   logic [31:0] expQ [$];
   logic        oeSeen = 1'b0;

   sccb_slave_regfile dut (
      .iCLK       (clk),
      .iRST       (rst),
      .I2C_SCLK   (scl),
      .I2C_SDAT   (sdaBus),
      .oSDA_OE    (oe),
      .iRD_ADDR   (rdAddr),
      .oRD_DATA   (rdData),
      .oWR_STROBE (wrStrobe),
      .oWR_ADDR   (wrAddr),
      .oWR_DATA   (wrData),
      .oBUSY      (busy),
      .oWR_COUNT  (wrCount)
   );

   always #5 clk = ~clk;

   // Pull-up modelled by the bench: it only floats when the target pulls low.
   assign sdaBus = (oe && !mLow) ? 1'bz : ~mLow;

   task automatic check(input string name, input logic [31:0] act,
                        input logic [31:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (oe) oeSeen = 1'b1;
      if (!rst && wrStrobe) begin
         check("strobe pending", 32'(expQ.size() > 0), 32'd1);
         if (expQ.size() > 0) begin
            logic [31:0] e;
            e = expQ.pop_front();
            check("wr addr", 32'(wrAddr), 32'(e[15:8]));
            check("wr data", 32'(wrData), 32'(e[7:0]));
            check("wr count", 32'(wrCount), 32'(e[31:16]));
         end
      end
   end

   task automatic q();
      repeat (10) @(posedge clk);
      #1;
   endtask

   task automatic sendBit(input logic b);
      mLow = ~b;
      q();
      scl = 1'b1;
      q();
      q();
      scl = 1'b0;
      q();
   endtask

   task automatic recvBit(output logic b);
      mLow = 1'b0;
      q();
      scl = 1'b1;
      q();
      b = sdaBus;
      q();
      scl = 1'b0;
      q();
   endtask

   task automatic startC();
      mLow = 1'b0;
      q();
      scl = 1'b1;
      q();
      mLow = 1'b1;
      q();
      scl = 1'b0;
      q();
   endtask

   task automatic stopC();
      mLow = 1'b1;
      q();
      scl = 1'b1;
      q();
      mLow = 1'b0;
      q();
      q();
   endtask

   task automatic writeByte(input logic [7:0] b, output logic ack);
      for (int i = 7; i >= 0; i--) sendBit(b[i]);
      recvBit(ack);
   endtask

   task automatic readByte(output logic [7:0] b, input logic ackBit);
      logic t;
      for (int i = 7; i >= 0; i--) begin
         recvBit(t);
         b[i] = t;
      end
      sendBit(ackBit);
   endtask

   task automatic busWrite(input logic [7:0] sub, input logic [7:0] d0,
                           input logic [7:0] d1, input int n);
      logic       a;
      logic [7:0] p;
      logic [7:0] d;
      startC();
      writeByte(8'h42, a);
      check("id ack", 32'(a), 32'd0);
      writeByte(sub, a);
      check("sub ack", 32'(a), 32'd0);
      p = sub;
      for (int k = 0; k < n; k++) begin
         d = (k == 0) ? d0 : d1;
         mReg[p] = d;
         if (mCount < 65535) mCount++;
         expQ.push_back({16'(mCount), p, d});
         writeByte(d, a);
         check("data ack", 32'(a), 32'd0);
         p = p + 8'd1;
      end
      stopC();
   endtask

   task automatic hostRead(input logic [7:0] a, output logic [7:0] d);
      rdAddr = a;
      @(posedge clk);
      #1;
      d = rdData;
   endtask

   task automatic checkReg(input string name, input logic [7:0] a,
                           input logic [7:0] exp);
      logic [7:0] d;
      hostRead(a, d);
      check(name, 32'(d), 32'(exp));
   endtask

   initial begin
      logic       a;
      logic [7:0] b0;
      logic [7:0] b1;
      int         c0;
      for (int i = 0; i < 256; i++) mReg[i] = 8'h00;

      repeat (3) @(posedge clk);
      #1;
      check("reset oe", 32'(oe), 32'd0);
      check("reset busy", 32'(busy), 32'd0);
      check("reset strobe", 32'(wrStrobe), 32'd0);
      check("reset count", 32'(wrCount), 32'd0);
      check("reset rd data", 32'(rdData), 32'd0);
      check("reset wr addr", 32'(wrAddr), 32'd0);
      check("reset wr data", 32'(wrData), 32'd0);
      rst = 1'b0;
      q();

      // Single write
      busWrite(8'h12, 8'h80, 8'h00, 1);
      checkReg("reg12 lit", 8'h12, 8'h80);
      checkReg("reg12 model", 8'h12, mReg[8'h12]);
      check("count lit", 32'(wrCount), 32'd1);
      check("strobes drained", 32'(expQ.size()), 32'd0);

      // Wrong device ID
      oeSeen = 1'b0;
      startC();
      writeByte(8'h60, a);
      check("wrong id nack", 32'(a), 32'd1);
      check("wrong id busy", 32'(busy), 32'd0);
      writeByte(8'h12, a);
      writeByte(8'h55, a);
      stopC();
      check("wrong id oe", 32'(oeSeen), 32'd0);
      check("wrong id busy end", 32'(busy), 32'd0);
      checkReg("reg12 kept", 8'h12, mReg[8'h12]);
      check("wrong id count", 32'(wrCount), 32'(mCount));

      // Read after write, separate transactions
      busWrite(8'h3A, 8'h04, 8'h00, 1);
      startC();
      writeByte(8'h42, a);
      writeByte(8'h3A, a);
      stopC();
      startC();
      writeByte(8'h43, a);
      check("rd id ack", 32'(a), 32'd0);
      check("rd busy", 32'(busy), 32'd1);
      readByte(b0, 1'b1);
      check("rd byte lit", 32'(b0), 32'h04);
      check("rd byte model", 32'(b0), 32'(mReg[8'h3A]));
      check("nack sda", 32'(sdaBus), 32'd1);
      check("nack oe", 32'(oe), 32'd0);
      stopC();
      check("rd busy end", 32'(busy), 32'd0);

      // Burst across the FF->00 wrap
      c0 = mCount;
      busWrite(8'hFF, 8'h11, 8'h22, 2);
      checkReg("regFF", 8'hFF, 8'h11);
      checkReg("reg00", 8'h00, 8'h22);
      check("burst count", 32'(wrCount), 32'(c0 + 2));

      // Repeated START, two-byte read
      busWrite(8'h0C, 8'hC3, 8'h5A, 2);
      startC();
      writeByte(8'h42, a);
      writeByte(8'h0C, a);
      startC();
      writeByte(8'h43, a);
      check("rs id ack", 32'(a), 32'd0);
      readByte(b0, 1'b0);
      readByte(b1, 1'b1);
      stopC();
      check("rs byte0", 32'(b0), 32'hC3);
      check("rs byte1", 32'(b1), 32'h5A);
      check("rs byte1 model", 32'(b1), 32'(mReg[8'h0D]));

      // Reset in the middle of bit 4 of a read of 0x04
      startC();
      writeByte(8'h42, a);
      writeByte(8'h3A, a);
      startC();
      writeByte(8'h43, a);
      for (int i = 0; i < 3; i++) recvBit(b0[0]);
      mLow = 1'b0;
      q();
      scl = 1'b1;
      @(posedge clk);
      #1;
      check("bit4 driven", 32'(oe), 32'd1);
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      check("mid reset oe", 32'(oe), 32'd0);
      check("mid reset busy", 32'(busy), 32'd0);
      for (int i = 0; i < 256; i++) mReg[i] = 8'h00;
      mCount = 0;
      expQ.delete();
      for (int i = 0; i < 256; i++) begin
         checkReg("cleared reg", 8'(i), mReg[i]);
      end
      check("mid reset count", 32'(wrCount), 32'd0);
      scl = 1'b0;
      q();
      stopC();
      busWrite(8'h20, 8'hA5, 8'h00, 1);
      checkReg("post reset reg", 8'h20, 8'hA5);
      check("post reset count", 32'(wrCount), 32'd1);
      check("final drained", 32'(expQ.size()), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               compared, mismatched);
      $finish;
   end

   initial begin
      #3000000;
      mismatched++;
      $display("FAIL watchdog: bench did not reach its end in time");
      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               compared, mismatched);
      $fatal(1, "watchdog expired");
   end

endmodule
